sa_cache_sim: RTL and testbench
===============================

Name: sa_cache_sim

Overview:
- Tag-only (no data) set-associative cache simulator core. It is the parametrised successor of the direct-mapped simulator top.
- Accepts one trace address per handshake and classifies it as hit or miss. On a miss it allocates a line using true-LRU replacement.
- Keeps saturating hit, miss and eviction counters for readout by the trace bench or an FPGA host.
- Supports a bulk flush of all sets and a statistics clear.

Parameters:
- ADDR_W, 32, trace address width.
- OFFSET_W, 6, block offset bits (64-byte line).
- INDEX_W, 7, set index bits (128 sets).
- WAYS, 4, associativity; power of two, minimum 1.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- trace_ready  in  1  a new address is valid on mem_addr.
- mem_addr  in  ADDR_W  trace address.
- flush  in  1  request to invalidate the whole cache.
- clear_stats  in  1  synchronous clear of all counters.
- busy  out  1  core is not in IDLE.
- found_in_cache  out  1  one-cycle hit pulse.
- updated  out  1  one-cycle miss/fill-complete pulse.
- flush_done  out  1  one-cycle pulse when a flush completes.
- cache_hit_count  out  CNT_W  number of hits.
- cache_miss_count  out  CNT_W  number of misses.
- evict_count  out  CNT_W  number of misses that replaced a valid line.

Behaviour:
- Address split: offset = mem_addr[OFFSET_W-1:0], index = next INDEX_W bits, tag = remaining ADDR_W-OFFSET_W-INDEX_W upper bits.
- Storage per set and way: valid bit, tag, and a log2(WAYS)-bit age.
- Reset (async, rst_n=0):
  - All valid bits = 0; all ages = WAYS-1.
  - All counters = 0; all pulse outputs = 0; busy = 0.
  - State = IDLE.
  - Reset mid-operation abandons the access with no counter change.
- FSM states: IDLE, LOOKUP, FILL, FLUSH.
- IDLE:
  - flush=1 goes to FLUSH. Flush wins over a simultaneous trace_ready.
  - Otherwise trace_ready=1 latches the address and goes to LOOKUP.
  - trace_ready and flush are ignored in every state other than IDLE. The bench waits for a pulse before issuing the next request.
- LOOKUP (one cycle):
  - Compare the tag against all valid ways of the set.
  - Hit: found_in_cache=1 in the following cycle; hit count +1; LRU touch of the hit way; go to IDLE.
  - Miss: go to FILL.
  - Hit latency: found_in_cache high in the 2nd cycle after the accepting edge.
- FILL (one cycle):
  - Victim = lowest-numbered invalid way if any exist, else the way with age WAYS-1.
  - Write the tag, set valid, LRU touch of the victim.
  - Miss count +1; evict count +1 if the victim was valid.
  - updated=1 in the following cycle; go to IDLE.
  - Miss latency: updated high in the 3rd cycle after the accepting edge.
- LRU touch of way w with prior age a: every other way in the set with age < a increments; way w gets age 0. Valid ways therefore always hold distinct ages.
- FLUSH:
  - Set counter starts at 0 and clears valid bits and resets ages (to WAYS-1) of one set per cycle.
  - After set 2^INDEX_W-1: flush_done=1 for one cycle; go to IDLE.
  - Total time is 2^INDEX_W cycles plus one for the pulse.
  - Counters are not affected by a flush.
- Counters:
  - Each counter saturates at 2^CNT_W-1.
  - clear_stats=1 zeroes all three counters on that edge; clear wins over a same-cycle increment.
  - clear_stats is honoured in any state.
- busy = (state != IDLE), registered.
- At most one of found_in_cache and updated is high in any cycle.
- WAYS=1 degenerates to direct-mapped with identical handshake and latencies.

Test Plan:
- Defaults assumed below: set 0, tag = addr[31:13].
- Cold miss: reset, request 0x00000000.
  - updated pulses 3 cycles after accept.
  - miss=1, hit=0, evict=0.
  - Then request 0x0000003F: found_in_cache 2 cycles after accept; hit=1.
- LRU eviction:
  - Request 0x0000, 0x2000, 0x4000, 0x6000 → 4 misses.
  - Request 0x0000 → hit.
  - Request 0x8000 → miss, evict=1; 0x2000 is the victim.
  - Request 0x2000 → miss; 0x0000 → hit.
  - Final counts: miss=6, hit=2, evict=2.
- Flush:
  - After the LRU sequence, pulse flush: busy for 128 cycles, then flush_done.
  - Request 0x0000 → miss; counters are not cleared.
  - A trace_ready raised during the flush is ignored.
- Simultaneous events:
  - flush and trace_ready high together in IDLE → FLUSH entered, address dropped.
  - clear_stats on the same edge as a hit → hit count reads 0.
- Saturation: CNT_W=4, 20 distinct cold misses → miss count holds at 15.
- Reset mid-op: assert rst_n=0 during FILL → no pulse, counters 0; after release, the same address misses.

Source files
------------

// File: rtl/sa_cache_sim_if.sv
// Trace/statistics bus of the set-associative cache simulator core.
//   master : trace source / host side (drives requests, reads results)
//   slave  : the cache core
// Signals:
//   trace_ready      master->slave  new address valid on mem_addr
//   mem_addr         master->slave  trace address
//   flush            master->slave  invalidate the whole cache
//   clear_stats      master->slave  zero all statistics counters
//   busy             slave->master  core is not idle
//   found_in_cache   slave->master  one-cycle hit pulse
//   updated          slave->master  one-cycle miss/fill-complete pulse
//   flush_done       slave->master  one-cycle flush-complete pulse
//   cache_hit_count, cache_miss_count, evict_count  saturating statistics
interface sa_cache_sim_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              trace_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              flush;
    logic              clear_stats;
    logic              busy;
    logic              found_in_cache;
    logic              updated;
    logic              flush_done;
    logic [CNT_W-1:0]  cache_hit_count;
    logic [CNT_W-1:0]  cache_miss_count;
    logic [CNT_W-1:0]  evict_count;

    modport master (
        output trace_ready, mem_addr, flush, clear_stats,
        input  busy, found_in_cache, updated, flush_done,
               cache_hit_count, cache_miss_count, evict_count
    );

    modport slave (
        input  trace_ready, mem_addr, flush, clear_stats,
        output busy, found_in_cache, updated, flush_done,
               cache_hit_count, cache_miss_count, evict_count
    );
endinterface

// File: rtl/sa_cache_sim.sv
// Tag-only set-associative cache simulator core with true-LRU replacement.
// Classifies each accepted trace address as hit or miss, allocates on miss,
// and keeps saturating hit/miss/eviction counters. Supports a set-by-set
// bulk flush and a statistics clear.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sa_cache_sim_if.slave (request, flush, pulses and counters)
module sa_cache_sim #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 7,
    parameter int WAYS     = 4,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    sa_cache_sim_if.slave bus
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W = WAY_W;
    localparam logic [AGE_W-1:0] OLDEST_AGE = AGE_W'(WAYS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, FLUSH} state_t;

    state_t             state_reg, state_next;
    logic [INDEX_W-1:0] index_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [INDEX_W-1:0] flush_set_reg;
    logic               busy_reg, found_reg, updated_reg, flush_done_reg;
    logic               found_next, updated_next, flush_done_next;
    logic [CNT_W-1:0]   hit_cnt_reg, miss_cnt_reg, evict_cnt_reg;

    logic [WAYS-1:0]    valid_mem [SETS];
    logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
    logic [AGE_W-1:0]   age_mem   [SETS][WAYS];

    logic [WAYS-1:0]    set_valid, way_hit;
    logic [AGE_W-1:0]   set_age     [WAYS];
    logic [AGE_W-1:0]   touched_age [WAYS];
    logic [WAY_W-1:0]   hit_way, victim_way, touch_way;
    logic [AGE_W-1:0]   touch_age;
    logic               hit_any;
    logic               accept, flush_start, flush_step;
    logic               do_hit, do_miss, do_evict, do_touch, do_fill;

    // The latched set stays untouched between LOOKUP and FILL, so both
    // states read it straight from the arrays.
    assign set_valid = valid_mem[index_reg];
    assign hit_any   = |way_hit;
    assign touch_way = (state_reg == FILL) ? victim_way : hit_way;
    assign touch_age = set_age[touch_way];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign set_age[gi] = age_mem[index_reg][gi];
            assign way_hit[gi] = set_valid[gi] && (tag_mem[index_reg][gi] == tag_reg);
            // LRU touch: younger ways than the touched one age by one.
            assign touched_age[gi] = (WAY_W'(gi) == touch_way) ? '0 :
                                     (set_age[gi] < touch_age)  ? set_age[gi] + 1'b1 :
                                                                  set_age[gi];
        end
    endgenerate

    // Descending scans so the lowest-numbered match wins. An invalid way
    // overrides the oldest-age choice; with all ways valid the ages are
    // distinct, so exactly one way holds OLDEST_AGE.
    always_comb begin
        hit_way    = '0;
        victim_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) hit_way = WAY_W'(i);
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (set_age[i] == OLDEST_AGE) victim_way = WAY_W'(i);
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!set_valid[i]) victim_way = WAY_W'(i);
        end
    end

    always_comb begin
        state_next      = state_reg;
        found_next      = 1'b0;
        updated_next    = 1'b0;
        flush_done_next = 1'b0;
        accept          = 1'b0;
        flush_start     = 1'b0;
        flush_step      = 1'b0;
        do_hit          = 1'b0;
        do_miss         = 1'b0;
        do_evict        = 1'b0;
        do_touch        = 1'b0;
        do_fill         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.flush) begin
                    flush_start = 1'b1;
                    state_next  = FLUSH;
                end else if (bus.trace_ready) begin
                    accept     = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    found_next = 1'b1;
                    do_hit     = 1'b1;
                    do_touch   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = FILL;
                end
            end
            FILL: begin
                updated_next = 1'b1;
                do_miss      = 1'b1;
                do_evict     = set_valid[victim_way];
                do_touch     = 1'b1;
                do_fill      = 1'b1;
                state_next   = IDLE;
            end
            FLUSH: begin
                flush_step = 1'b1;
                if (flush_set_reg == INDEX_W'(SETS - 1)) begin
                    flush_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            found_reg      <= 1'b0;
            updated_reg    <= 1'b0;
            flush_done_reg <= 1'b0;
            index_reg      <= '0;
            tag_reg        <= '0;
            flush_set_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            busy_reg       <= (state_next != IDLE);
            found_reg      <= found_next;
            updated_reg    <= updated_next;
            flush_done_reg <= flush_done_next;
            if (accept) begin
                index_reg <= bus.mem_addr[OFFSET_W +: INDEX_W];
                tag_reg   <= bus.mem_addr[ADDR_W-1 -: TAG_W];
            end
            if (flush_start) begin
                flush_set_reg <= '0;
            end else if (flush_step) begin
                flush_set_reg <= flush_set_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_mem[s][w] <= OLDEST_AGE;
                end
            end
        end else begin
            if (flush_step) begin
                valid_mem[flush_set_reg] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_mem[flush_set_reg][w] <= OLDEST_AGE;
                end
            end
            if (do_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_mem[index_reg][w] <= touched_age[w];
                end
            end
            if (do_fill) begin
                valid_mem[index_reg][victim_way] <= 1'b1;
            end
        end
    end

    // Tags are only meaningful under a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_mem[index_reg][victim_way] <= tag_reg;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
            evict_cnt_reg <= '0;
        end else if (bus.clear_stats) begin
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
            evict_cnt_reg <= '0;
        end else begin
            if (do_hit)   hit_cnt_reg   <= sat_inc(hit_cnt_reg);
            if (do_miss)  miss_cnt_reg  <= sat_inc(miss_cnt_reg);
            if (do_evict) evict_cnt_reg <= sat_inc(evict_cnt_reg);
        end
    end

    assign bus.busy             = busy_reg;
    assign bus.found_in_cache   = found_reg;
    assign bus.updated          = updated_reg;
    assign bus.flush_done       = flush_done_reg;
    assign bus.cache_hit_count  = hit_cnt_reg;
    assign bus.cache_miss_count = miss_cnt_reg;
    assign bus.evict_count      = evict_cnt_reg;
endmodule

// File: tb/tb_sa_cache_sim.sv
// Self-checking bench for sa_cache_sim: directed scenarios plus randomized
// traffic checked against a per-set MRU-ordered tag list model. A second
// instance with 4-bit counters exercises counter saturation.
module tb_sa_cache_sim;
    localparam int WAYS = 4;
    localparam int SETS = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_cache_sim_if #(.ADDR_W(32), .CNT_W(32)) bus ();
    sa_cache_sim_if #(.ADDR_W(32), .CNT_W(4))  bus_sat ();

    sa_cache_sim #(.ADDR_W(32), .OFFSET_W(6), .INDEX_W(7), .WAYS(WAYS), .CNT_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sa_cache_sim #(.ADDR_W(32), .OFFSET_W(6), .INDEX_W(7), .WAYS(WAYS), .CNT_W(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    int check_count = 0;
    int error_count = 0;

    // Reference model: per set, resident tags ordered most- to least-recently used.
    int unsigned mdl_tags [SETS][$];
    longint unsigned mdl_hit, mdl_miss, mdl_evict;

    task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) mdl_tags[s].delete();
        mdl_hit = 0;
        mdl_miss = 0;
        mdl_evict = 0;
    endtask

    task automatic model_access(input logic [31:0] addr, output bit hit, output bit evict);
        int unsigned idx;
        int unsigned tg;
        idx = int'(addr[12:6]);
        tg  = int'(addr[31:13]);
        hit = 1'b0;
        evict = 1'b0;
        for (int i = 0; i < mdl_tags[idx].size(); i++) begin
            if (!hit && mdl_tags[idx][i] == tg) begin
                hit = 1'b1;
                mdl_tags[idx].delete(i);
                break;
            end
        end
        if (!hit && mdl_tags[idx].size() == WAYS) begin
            void'(mdl_tags[idx].pop_back());
            evict = 1'b1;
        end
        mdl_tags[idx].push_front(tg);
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, "_hit_count"},   bus.cache_hit_count,  mdl_hit);
        check_val({tag, "_miss_count"},  bus.cache_miss_count, mdl_miss);
        check_val({tag, "_evict_count"}, bus.evict_count,      mdl_evict);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // One trace access; clr raises clear_stats across the lookup edge.
    task automatic do_access(input logic [31:0] addr, input bit clr);
        bit exp_hit, exp_evict, both, pulse_hit;
        int pulse_cyc;
        @(negedge clk);
        bus.mem_addr = addr;
        bus.trace_ready = 1'b1;
        @(posedge clk);
        #1 bus.trace_ready = 1'b0;
        model_access(addr, exp_hit, exp_evict);
        if (clr) begin
            mdl_hit = 0;
            mdl_miss = 0;
            mdl_evict = 0;
        end
        if (!exp_hit) begin
            mdl_miss++;
            if (exp_evict) mdl_evict++;
        end else if (!clr) begin
            mdl_hit++;
        end
        pulse_cyc = 0;
        pulse_hit = 1'b0;
        both = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.found_in_cache && bus.updated) both = 1'b1;
            if (pulse_cyc == 0 && (bus.found_in_cache || bus.updated)) begin
                pulse_cyc = k;
                pulse_hit = bus.found_in_cache;
            end
            bus.clear_stats = (k == 1) ? clr : 1'b0;
        end
        $display("access addr=%08h clr=%0d exp_hit=%0d pulse_cycle=%0d hits=%0d misses=%0d evicts=%0d",
                 addr, clr, exp_hit, pulse_cyc, bus.cache_hit_count, bus.cache_miss_count, bus.evict_count);
        check_val("pulse_cycle", pulse_cyc, exp_hit ? 2 : 3);
        check_val("pulse_is_hit", pulse_hit, exp_hit);
        check_val("dual_pulse", both, 0);
        check_counters("access");
    endtask

    // Flush; optionally with a simultaneous trace_ready, and/or a request
    // poked in the middle of the flush (both must be ignored).
    task automatic do_flush(input bit with_trace, input bit poke_during);
        int busy_cyc, done_k;
        @(negedge clk);
        bus.flush = 1'b1;
        if (with_trace) begin
            bus.trace_ready = 1'b1;
            bus.mem_addr = 32'h0000_0000;
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.trace_ready = 1'b0;
        busy_cyc = 0;
        done_k = 0;
        for (int k = 1; k <= 200 && done_k == 0; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.flush_done) done_k = k;
            if (poke_during) begin
                bus.trace_ready = (k == 40);
                bus.mem_addr = 32'h0000_2000;
            end
        end
        bus.trace_ready = 1'b0;
        for (int s = 0; s < SETS; s++) mdl_tags[s].delete();
        $display("flush with_trace=%0d poke=%0d busy_cycles=%0d done_cycle=%0d", with_trace, poke_during, busy_cyc, done_k);
        check_val("flush_busy_cycles", busy_cyc, SETS);
        check_val("flush_done_cycle", done_k, SETS + 1);
        check_counters("flush");
        @(negedge clk);
        check_val("flush_done_one_cycle", bus.flush_done, 0);
        check_val("flush_idle_after", bus.busy, 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        bus.trace_ready = 1'b0;
        bus.mem_addr = '0;
        bus.flush = 1'b0;
        bus.clear_stats = 1'b0;
        bus_sat.trace_ready = 1'b0;
        bus_sat.mem_addr = '0;
        bus_sat.flush = 1'b0;
        bus_sat.clear_stats = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_found", bus.found_in_cache, 0);
        check_val("rst_updated", bus.updated, 0);
        check_val("rst_flush_done", bus.flush_done, 0);
        check_counters("rst");

        // Cold miss then hit within the same line
        do_access(32'h0000_0000, 1'b0);
        check_val("cold_miss_count", bus.cache_miss_count, 1);
        do_access(32'h0000_003F, 1'b0);
        check_val("cold_hit_count", bus.cache_hit_count, 1);

        // LRU eviction sequence from a clean start
        reset_dut();
        do_access(32'h0000_0000, 1'b0);
        do_access(32'h0000_2000, 1'b0);
        do_access(32'h0000_4000, 1'b0);
        do_access(32'h0000_6000, 1'b0);
        do_access(32'h0000_0000, 1'b0);
        do_access(32'h0000_8000, 1'b0);
        do_access(32'h0000_2000, 1'b0);
        do_access(32'h0000_0000, 1'b0);
        check_val("lru_miss_total", bus.cache_miss_count, 6);
        check_val("lru_hit_total", bus.cache_hit_count, 2);
        check_val("lru_evict_total", bus.evict_count, 2);

        // Flush with an ignored request in the middle, then a resident line misses
        do_flush(1'b0, 1'b1);
        do_access(32'h0000_0000, 1'b0);
        check_val("post_flush_miss", bus.cache_miss_count, 7);

        // flush and trace_ready together: flush wins, address dropped
        do_flush(1'b1, 1'b0);

        // clear_stats on the hit edge
        do_access(32'h0000_4000, 1'b0);
        do_access(32'h0000_4000, 1'b1);
        check_val("clear_on_hit", bus.cache_hit_count, 0);

        // Randomized traffic over a few sets with more tags than ways
        for (int n = 0; n < 250; n++) begin
            addr = ($urandom_range(0, 5) << 13) | ($urandom_range(0, 2) << 6) | $urandom_range(0, 63);
            if ($urandom_range(0, 59) == 0) do_flush(1'b0, 1'b0);
            do_access(addr, $urandom_range(0, 24) == 0);
        end

        // Reset asserted during FILL
        reset_dut();
        @(negedge clk);
        bus.mem_addr = 32'h0001_2340;
        bus.trace_ready = 1'b1;
        @(posedge clk);
        #1 bus.trace_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("midop_no_pulse", bus.found_in_cache | bus.updated, 0);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_val("midop_busy", bus.busy, 0);
        check_counters("midop");
        do_access(32'h0001_2340, 1'b0);
        check_val("midop_rerun_miss", bus.cache_miss_count, 1);

        // Saturation on the 4-bit-counter instance: 20 distinct cold misses in set 0
        for (int i = 0; i < 20; i++) begin
            int seen;
            @(negedge clk);
            bus_sat.mem_addr = (i + 1) << 13;
            bus_sat.trace_ready = 1'b1;
            @(posedge clk);
            #1 bus_sat.trace_ready = 1'b0;
            seen = 0;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (bus_sat.updated && seen == 0) seen = k;
            end
            $display("sat access=%0d updated_cycle=%0d misses=%0d evicts=%0d",
                     i, seen, bus_sat.cache_miss_count, bus_sat.evict_count);
            check_val("sat_updated_cycle", seen, 3);
            check_val("sat_miss_count", bus_sat.cache_miss_count, (i + 1 > 15) ? 15 : i + 1);
            check_val("sat_evict_count", bus_sat.evict_count,
                      (i + 1 <= WAYS) ? 0 : ((i + 1 - WAYS > 15) ? 15 : i + 1 - WAYS));
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end
endmodule
